sequence_detector_moore_verilog: RTL and testbench
==================================================

SEQUENCE_DETECTOR_MOORE_VERILOG -- requirements
Module: sequence_detector_moore_verilog

Interface
REQ-001 Parameters: none; the detected pattern is fixed at 1011 (first-received bit first).
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled only on the rising clock edge.
REQ-004 sequence_in  input  1  serial data bit, one bit sampled per rising clock edge.
REQ-005 detector_out  output  1  high while the FSM is in the pattern-complete state.

Function
REQ-006 The block SHALL be a Moore FSM; detector_out SHALL depend only on the current state register, never directly on sequence_in.
REQ-007 States SHALL be: S_ZERO (nothing matched), S_ONE ("1"), S_ONE_ZERO ("10"), S_ONE_ZERO_ONE ("101"), S_DETECT ("1011"), encoded in a 3-bit register.
REQ-008 Transitions on each rising edge with reset low (in=0 / in=1):
 - S_ZERO -> S_ZERO / S_ONE
 - S_ONE -> S_ONE_ZERO / S_ONE
 - S_ONE_ZERO -> S_ZERO / S_ONE_ZERO_ONE
 - S_ONE_ZERO_ONE -> S_ONE_ZERO / S_DETECT
 - S_DETECT -> S_ONE_ZERO / S_ONE
REQ-009 Detection SHALL be overlapping: the trailing "1" of a match counts as the leading "1" of the next candidate, and a trailing "10" after a match advances to S_ONE_ZERO.
REQ-010 detector_out SHALL be 1 exactly when state = S_DETECT, else 0.
REQ-011 Latency: detector_out SHALL rise in the clock cycle immediately following the rising edge that samples the fourth bit of a matching 1011, and SHALL stay high for exactly one cycle per match.
REQ-012 Back-to-back detections (input 1011011) SHALL produce two one-cycle pulses three cycles apart.
REQ-013 The three unused state encodings SHALL transition to S_ZERO on the next rising edge, with detector_out = 0 while in them.
REQ-014 The block SHALL contain no latches and no combinational path from sequence_in to detector_out.

Reset
REQ-015 When reset is high at a rising edge, the state SHALL become S_ZERO regardless of sequence_in or the current state; detector_out SHALL therefore be 0 in the following cycle.
REQ-016 Reset SHALL have priority over every transition, including an edge that would otherwise complete a match.
REQ-017 Before the first rising edge with reset high, the outputs are undefined; after that edge, detector_out SHALL be 0.
REQ-018 After reset deasserts, a complete fresh 1011 SHALL be required for detection; partial matches made before reset SHALL NOT be retained.

Verification
REQ-019 Reset high for 3 edges with sequence_in toggling -> detector_out = 0 throughout and after release with sequence_in = 0.
REQ-020 After reset, drive 1,0,1,1,0 on successive edges -> detector_out = 0,0,0,1,0 in the cycles following those edges.
REQ-021 Overlap: drive 1,0,1,1,0,1,1 -> detector_out high only in the cycles after bit 4 and bit 7.
REQ-022 Drive 1,1,0,0,1,1,1,1,0,0 (each bit one edge) -> detector_out never asserts.
REQ-023 Drive 1,0,0,1,0,1,1 -> single pulse after bit 7 only, confirming fallback from S_ONE_ZERO to S_ZERO on 0.
REQ-024 Drive 1,0,1, then assert reset on the edge where sequence_in = 1 -> detector_out stays 0; the next 1 alone after reset release gives no pulse.

Source files
------------

// File: rtl/sequence_detector_moore_verilog.sv
// sequence_detector_moore_verilog: Moore FSM flagging each overlapping 1011 on a serial input
module sequence_detector_moore_verilog (
  input  logic clock,
  input  logic reset,
  input  logic sequence_in,
  output logic detector_out
);
  localparam logic [2:0] S_ZERO         = 3'd0;
  localparam logic [2:0] S_ONE          = 3'd1;
  localparam logic [2:0] S_ONE_ZERO     = 3'd2;
  localparam logic [2:0] S_ONE_ZERO_ONE = 3'd3;
  localparam logic [2:0] S_DETECT       = 3'd4;
  logic [2:0] state_q, state_d;
  always_comb begin
    state_d = S_ZERO;
    case (state_q)
      S_ZERO:         state_d = sequence_in ? S_ONE : S_ZERO;
      S_ONE:          state_d = sequence_in ? S_ONE : S_ONE_ZERO;
      S_ONE_ZERO:     state_d = sequence_in ? S_ONE_ZERO_ONE : S_ZERO;
      S_ONE_ZERO_ONE: state_d = sequence_in ? S_DETECT : S_ONE_ZERO;
      S_DETECT:       state_d = sequence_in ? S_ONE : S_ONE_ZERO;
      default:        state_d = S_ZERO;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_ZERO;
    else state_q <= state_d;
  end
  assign detector_out = (state_q == S_DETECT);
endmodule

// File: tb/tb_sequence_detector_moore_verilog.sv
// tb_sequence_detector_moore_verilog: directed and random 1011 detection checks against a history model
module tb_sequence_detector_moore_verilog;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sequence_in = 1'b0;
  logic detector_out;
  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  logic [3:0] hist = 4'b0;
  int valid = 0;

  sequence_detector_moore_verilog dut (
    .clock(clock),
    .reset(reset),
    .sequence_in(sequence_in),
    .detector_out(detector_out)
  );

  always #5 clock = ~clock;

  task automatic step(input bit b, input bit r, input string tag);
    bit e;
    sequence_in = b;
    reset = r;
    @(posedge clock);
    if (r) begin
      hist = 4'b0;
      valid = 0;
    end else begin
      hist = {hist[2:0], b};
      if (valid < 4) valid++;
    end
    exp_q.push_back(!r && valid >= 4 && hist == 4'b1011);
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    assert (detector_out === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, detector_out, e);
    end
  endtask

  task automatic run(input logic [15:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b0, tag);
  endtask

  initial begin
    @(negedge clock);
    for (int i = 0; i < 3; i++) step(i[0], 1'b1, "reset_hold");
    run(16'b000, 3, "reset_release");
    run(16'b10110, 5, "basic_1011");
    step(1'b1, 1'b1, "reset_mid");
    run(16'b1011011, 7, "overlap");
    step(1'b0, 1'b1, "reset_mid");
    run(16'b1100111100, 10, "no_match");
    step(1'b0, 1'b1, "reset_mid");
    run(16'b1001011, 7, "fallback");
    step(1'b0, 1'b1, "reset_mid");
    run(16'b101, 3, "prefix");
    step(1'b1, 1'b1, "reset_priority");
    run(16'b1000, 4, "after_reset");
    run(16'b1011, 4, "fresh_match");
    for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), 1'b0, "random");
    step(1'b1, 1'b1, "final_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
